// File: rtl/alu_rs_pkg.sv
// Shared widths, op codes and the reservation-station entry record for the ALU RS.
package alu_rs_pkg;

  localparam int RS_SIZE = 8;
  localparam int IDX_W   = 3;
  localparam int DATA_W  = 32;
  localparam int ROB_W   = 4;
  localparam int OP_W    = 4;

  localparam logic [DATA_W-1:0] ZERO_DATA = '0;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9
  } aluOp_e;

  // One waiting instruction: an operand is usable once its r flag is set,
  // otherwise q names the ROB entry that will broadcast it.
  typedef struct packed {
    logic              busy;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic [ROB_W-1:0]  qj;
    logic [ROB_W-1:0]  qk;
    logic              rj;
    logic              rk;
    logic [ROB_W-1:0]  robTag;
  } rsEntry_t;

  // True when a broadcast on one CDB port carries the value an operand waits for.
  function automatic logic cdbHit(input logic valid, input logic [ROB_W-1:0] tag,
                                  input logic [ROB_W-1:0] q);
    return valid && (tag == q);
  endfunction

endpackage

// File: rtl/rs_priority_pick.sv
// Lowest-index picker: returns the smallest set bit of a request vector plus an any-set flag.
module rs_priority_pick #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = W'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched integer ops, wakes operands from both CDBs,
// and issues the lowest-index ready entry into registered ALU inputs once per cycle.
module alu_rs
  import alu_rs_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DATA_W-1:0] in_vj,
  input  logic [DATA_W-1:0] in_vk,
  input  logic [ROB_W-1:0]  in_qj,
  input  logic [ROB_W-1:0]  in_qk,
  input  logic              in_rj,
  input  logic              in_rk,
  input  logic [ROB_W-1:0]  in_rob_tag,
  output logic              rs_full,
  input  logic              cdb_alu_valid,
  input  logic [ROB_W-1:0]  cdb_alu_tag,
  input  logic [DATA_W-1:0] cdb_alu_data,
  input  logic              cdb_lsb_valid,
  input  logic [ROB_W-1:0]  cdb_lsb_tag,
  input  logic [DATA_W-1:0] cdb_lsb_data,
  output logic              alu_ena,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [ROB_W-1:0]  alu_rob_tag
);

  rsEntry_t rs_q [RS_SIZE];
  rsEntry_t rs_d [RS_SIZE];
  rsEntry_t newEntry;

  logic [RS_SIZE-1:0] busyVec;
  logic [RS_SIZE-1:0] readyVec;
  logic [IDX_W-1:0]   freeIdx;
  logic [IDX_W-1:0]   readyIdx;
  logic               freeAny;
  logic               readyAny;
  logic               dispatchEn;

  logic              aluEna_q;
  logic [OP_W-1:0]   aluOp_q;
  logic [DATA_W-1:0] aluA_q;
  logic [DATA_W-1:0] aluB_q;
  logic [ROB_W-1:0]  aluTag_q;

  // Occupancy and readiness are taken from the pre-edge state only, so a slot freed
  // or woken at this edge is not visible to the pickers until the next one.
  always_comb begin
    busyVec  = '0;
    readyVec = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      busyVec[i]  = rs_q[i].busy;
      readyVec[i] = rs_q[i].busy & rs_q[i].rj & rs_q[i].rk;
    end
  end

  rs_priority_pick #(.N(RS_SIZE), .W(IDX_W)) u_freePick (
    .req_i (~busyVec),
    .idx_o (freeIdx),
    .any_o (freeAny)
  );

  rs_priority_pick #(.N(RS_SIZE), .W(IDX_W)) u_readyPick (
    .req_i (readyVec),
    .idx_o (readyIdx),
    .any_o (readyAny)
  );

  assign rs_full    = &busyVec;
  assign dispatchEn = in_valid & freeAny;

  // Build the incoming entry, grabbing an operand straight off a CDB broadcast at the
  // same edge so it never misses a producer that completes while it is being dispatched.
  always_comb begin
    newEntry        = '0;
    newEntry.busy   = 1'b1;
    newEntry.op     = in_op;
    newEntry.vj     = in_vj;
    newEntry.vk     = in_vk;
    newEntry.qj     = in_qj;
    newEntry.qk     = in_qk;
    newEntry.rj     = in_rj;
    newEntry.rk     = in_rk;
    newEntry.robTag = in_rob_tag;
    if (!in_rj) begin
      if (cdbHit(cdb_alu_valid, cdb_alu_tag, in_qj)) begin
        newEntry.vj = cdb_alu_data;
        newEntry.rj = 1'b1;
      end else if (cdbHit(cdb_lsb_valid, cdb_lsb_tag, in_qj)) begin
        newEntry.vj = cdb_lsb_data;
        newEntry.rj = 1'b1;
      end
    end
    if (!in_rk) begin
      if (cdbHit(cdb_alu_valid, cdb_alu_tag, in_qk)) begin
        newEntry.vk = cdb_alu_data;
        newEntry.rk = 1'b1;
      end else if (cdbHit(cdb_lsb_valid, cdb_lsb_tag, in_qk)) begin
        newEntry.vk = cdb_lsb_data;
        newEntry.rk = 1'b1;
      end
    end
  end

  // Next table state: wake waiting operands (ALU port first on a tag tie), retire the
  // issued entry, and drop the new instruction into the free slot, which is never the issued one.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      rs_d[i] = rs_q[i];
      if (rs_q[i].busy) begin
        if (!rs_q[i].rj) begin
          if (cdbHit(cdb_alu_valid, cdb_alu_tag, rs_q[i].qj)) begin
            rs_d[i].vj = cdb_alu_data;
            rs_d[i].rj = 1'b1;
          end else if (cdbHit(cdb_lsb_valid, cdb_lsb_tag, rs_q[i].qj)) begin
            rs_d[i].vj = cdb_lsb_data;
            rs_d[i].rj = 1'b1;
          end
        end
        if (!rs_q[i].rk) begin
          if (cdbHit(cdb_alu_valid, cdb_alu_tag, rs_q[i].qk)) begin
            rs_d[i].vk = cdb_alu_data;
            rs_d[i].rk = 1'b1;
          end else if (cdbHit(cdb_lsb_valid, cdb_lsb_tag, rs_q[i].qk)) begin
            rs_d[i].vk = cdb_lsb_data;
            rs_d[i].rk = 1'b1;
          end
        end
      end
    end
    if (readyAny) begin
      rs_d[readyIdx].busy = 1'b0;
    end
    if (dispatchEn) begin
      rs_d[freeIdx] = newEntry;
    end
  end

  // Register the table and the ALU launch; a flush wipes everything, and with nothing
  // ready the ALU operands simply hold their previous values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        rs_q[i] <= '0;
      end
      aluEna_q <= 1'b0;
      aluOp_q  <= '0;
      aluA_q   <= ZERO_DATA;
      aluB_q   <= ZERO_DATA;
      aluTag_q <= '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        rs_q[i] <= rs_d[i];
      end
      aluEna_q <= readyAny;
      if (readyAny) begin
        aluOp_q  <= rs_q[readyIdx].op;
        aluA_q   <= rs_q[readyIdx].vj;
        aluB_q   <= rs_q[readyIdx].vk;
        aluTag_q <= rs_q[readyIdx].robTag;
      end
    end
  end

  assign alu_ena     = aluEna_q;
  assign alu_op      = aluOp_q;
  assign alu_a       = aluA_q;
  assign alu_b       = aluB_q;
  assign alu_rob_tag = aluTag_q;

endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for the ALU reservation station: every expected issue is queued as the
// stimulus that causes it is driven, and popped whenever the DUT raises alu_ena.
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic              clk;
  logic              rst;
  logic              clear;
  logic              in_valid;
  logic [OP_W-1:0]   in_op;
  logic [DATA_W-1:0] in_vj;
  logic [DATA_W-1:0] in_vk;
  logic [ROB_W-1:0]  in_qj;
  logic [ROB_W-1:0]  in_qk;
  logic              in_rj;
  logic              in_rk;
  logic [ROB_W-1:0]  in_rob_tag;
  logic              rs_full;
  logic              cdb_alu_valid;
  logic [ROB_W-1:0]  cdb_alu_tag;
  logic [DATA_W-1:0] cdb_alu_data;
  logic              cdb_lsb_valid;
  logic [ROB_W-1:0]  cdb_lsb_tag;
  logic [DATA_W-1:0] cdb_lsb_data;
  logic              alu_ena;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [ROB_W-1:0]  alu_rob_tag;

  logic [71:0] expQ [$];
  int          vectorCount = 0;
  int          missCount   = 0;
  logic        monOn       = 1'b0;

  alu_rs dut (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .in_valid      (in_valid),
    .in_op         (in_op),
    .in_vj         (in_vj),
    .in_vk         (in_vk),
    .in_qj         (in_qj),
    .in_qk         (in_qk),
    .in_rj         (in_rj),
    .in_rk         (in_rk),
    .in_rob_tag    (in_rob_tag),
    .rs_full       (rs_full),
    .cdb_alu_valid (cdb_alu_valid),
    .cdb_alu_tag   (cdb_alu_tag),
    .cdb_alu_data  (cdb_alu_data),
    .cdb_lsb_valid (cdb_lsb_valid),
    .cdb_lsb_tag   (cdb_lsb_tag),
    .cdb_lsb_data  (cdb_lsb_data),
    .alu_ena       (alu_ena),
    .alu_op        (alu_op),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_rob_tag   (alu_rob_tag)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idleInputs();
    in_valid      = 1'b0;
    cdb_alu_valid = 1'b0;
    cdb_lsb_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] vj,
                               input logic [DATA_W-1:0] vk, input logic [ROB_W-1:0] qj,
                               input logic [ROB_W-1:0] qk, input logic rj, input logic rk,
                               input logic [ROB_W-1:0] tag);
    in_valid   = 1'b1;
    in_op      = op;
    in_vj      = vj;
    in_vk      = vk;
    in_qj      = qj;
    in_qk      = qk;
    in_rj      = rj;
    in_rk      = rk;
    in_rob_tag = tag;
  endtask

  task automatic driveCdbAlu(input logic [ROB_W-1:0] tag, input logic [DATA_W-1:0] data);
    cdb_alu_valid = 1'b1;
    cdb_alu_tag   = tag;
    cdb_alu_data  = data;
  endtask

  task automatic driveCdbLsb(input logic [ROB_W-1:0] tag, input logic [DATA_W-1:0] data);
    cdb_lsb_valid = 1'b1;
    cdb_lsb_tag   = tag;
    cdb_lsb_data  = data;
  endtask

  task automatic pushExp(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] a,
                         input logic [DATA_W-1:0] b, input logic [ROB_W-1:0] tag);
    expQ.push_back({op, a, b, tag});
  endtask

  task automatic drainQueue(input string tag, input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      step();
      n++;
    end
    #1;
    checkOutput(tag, expQ.size(), 0);
  endtask

  // Every cycle the ALU is launched must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (monOn && alu_ena === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("issue_pending", expQ.size(), 1);
      end else begin
        checkOutput("issue", {alu_op, alu_a, alu_b, alu_rob_tag}, expQ.pop_front());
      end
    end
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    clear = 1'b0;
    in_op = '0; in_vj = '0; in_vk = '0; in_qj = '0; in_qk = '0;
    in_rj = 1'b0; in_rk = 1'b0; in_rob_tag = '0;
    cdb_alu_tag = '0; cdb_alu_data = '0; cdb_lsb_tag = '0; cdb_lsb_data = '0;
    idleInputs();
    step();
    step();
    rst = 1'b0;
    checkOutput("rst_full", rs_full, 0);
    checkOutput("rst_ena", alu_ena, 0);
    checkOutput("rst_op", alu_op, 0);
    checkOutput("rst_a", alu_a, 0);
    checkOutput("rst_b", alu_b, 0);
    checkOutput("rst_tag", alu_rob_tag, 0);
    monOn = 1'b1;

    // Both operands ready at dispatch: one cycle in the station.
    applyStimulus(OP_ADD, 5, 7, 4'd0, 4'd0, 1'b1, 1'b1, 4'd3);
    pushExp(OP_ADD, 5, 7, 4'd3);
    step();
    idleInputs();
    checkOutput("lat_edge0_ena", alu_ena, 0);
    step();
    checkOutput("lat_edge1_ena", alu_ena, 1);
    checkOutput("alu_sum", alu_a + alu_b, 12);
    step();
    checkOutput("hold_ena", alu_ena, 0);
    checkOutput("hold_a", alu_a, 5);
    drainQueue("ready_drain", 2);

    // Wakeup from the ALU CDB, no issue on the wake edge itself.
    applyStimulus(OP_SUB, 0, 1, 4'd4, 4'd0, 1'b0, 1'b1, 4'd5);
    step();
    idleInputs();
    step();
    checkOutput("wait_ena", alu_ena, 0);
    driveCdbAlu(4'd4, 10);
    pushExp(OP_SUB, 10, 1, 4'd5);
    step();
    idleInputs();
    checkOutput("no_same_edge", alu_ena, 0);
    step();
    checkOutput("wake_issue", alu_ena, 1);
    drainQueue("wake_drain", 2);

    // Dispatch bypass from the load/store CDB.
    applyStimulus(OP_OR, 3, 0, 4'd0, 4'd6, 1'b1, 1'b0, 4'd7);
    driveCdbLsb(4'd6, 32'h55);
    pushExp(OP_OR, 3, 32'h55, 4'd7);
    step();
    idleInputs();
    step();
    checkOutput("bypass_issue", alu_ena, 1);
    drainQueue("bypass_drain", 2);

    // Two ports wake j and k of one entry, then equal tags where the ALU port wins.
    applyStimulus(OP_SLT, 0, 0, 4'd1, 4'd2, 1'b0, 1'b0, 4'd4);
    step();
    idleInputs();
    driveCdbAlu(4'd1, 32'hA);
    driveCdbLsb(4'd2, 32'hB);
    pushExp(OP_SLT, 32'hA, 32'hB, 4'd4);
    step();
    idleInputs();
    drainQueue("dual_drain", 3);
    applyStimulus(OP_AND, 0, 0, 4'd3, 4'd3, 1'b0, 1'b0, 4'd6);
    step();
    idleInputs();
    driveCdbAlu(4'd3, 32'hC);
    driveCdbLsb(4'd3, 32'hD);
    pushExp(OP_AND, 32'hC, 32'hC, 4'd6);
    step();
    idleInputs();
    drainQueue("tie_drain", 3);

    // Fill all eight entries waiting on tag 9; a ninth dispatch must be dropped.
    for (int i = 0; i < RS_SIZE; i++) begin
      applyStimulus(OP_ADD, DATA_W'(i), 0, 4'd0, 4'd9, 1'b1, 1'b0, ROB_W'(i));
      step();
    end
    idleInputs();
    checkOutput("full_set", rs_full, 1);
    applyStimulus(OP_ADD, 99, 1, 4'd0, 4'd0, 1'b1, 1'b1, 4'd15);
    step();
    idleInputs();
    checkOutput("full_hold", rs_full, 1);
    checkOutput("full_ignored", alu_ena, 0);
    step();
    checkOutput("full_ignored2", alu_ena, 0);
    driveCdbAlu(4'd9, 32'h20);
    for (int i = 0; i < RS_SIZE; i++) pushExp(OP_ADD, DATA_W'(i), 32'h20, ROB_W'(i));
    step();
    idleInputs();
    drainQueue("full_drain", 12);
    step();
    checkOutput("full_empty", rs_full, 0);
    repeat (3) step();

    // Entries 2 and 5 become ready together; lowest index first, then dispatch alongside issue.
    for (int i = 0; i < RS_SIZE; i++) begin
      applyStimulus(OP_XOR, 0, DATA_W'(i), (i == 2 || i == 5) ? 4'd10 : 4'd11, 4'd0,
                    1'b0, 1'b1, ROB_W'(i));
      step();
    end
    idleInputs();
    checkOutput("order_full", rs_full, 1);
    driveCdbAlu(4'd10, 32'h33);
    pushExp(OP_XOR, 32'h33, 2, 4'd2);
    pushExp(OP_XOR, 32'h33, 5, 4'd5);
    step();
    idleInputs();
    checkOutput("order_wake_ena", alu_ena, 0);
    step();
    checkOutput("order_first", alu_rob_tag, 2);
    applyStimulus(OP_AND, 32'hF0, 32'h0F, 4'd0, 4'd0, 1'b1, 1'b1, 4'd12);
    pushExp(OP_AND, 32'hF0, 32'h0F, 4'd12);
    step();
    idleInputs();
    checkOutput("order_second", alu_rob_tag, 5);
    checkOutput("order_count", rs_full, 0);
    step();
    checkOutput("order_new", alu_rob_tag, 12);
    drainQueue("order_drain", 3);
    driveCdbAlu(4'd11, 32'h44);
    for (int i = 0; i < RS_SIZE; i++) begin
      if (i != 2 && i != 5) pushExp(OP_XOR, 32'h44, DATA_W'(i), ROB_W'(i));
    end
    step();
    idleInputs();
    drainQueue("order_rest", 10);
    step();
    checkOutput("order_empty", rs_full, 0);

    // Flush with three waiting entries and a simultaneous dispatch.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(OP_ADD, DATA_W'(i), 1, 4'd13, 4'd0, 1'b0, 1'b1, ROB_W'(i));
      step();
    end
    applyStimulus(OP_ADD, 1, 1, 4'd0, 4'd0, 1'b1, 1'b1, 4'd8);
    clear = 1'b1;
    step();
    clear = 1'b0;
    idleInputs();
    checkOutput("flush_full", rs_full, 0);
    checkOutput("flush_ena", alu_ena, 0);
    checkOutput("flush_a", alu_a, 0);
    checkOutput("flush_op", alu_op, 0);
    driveCdbAlu(4'd13, 1);
    step();
    idleInputs();
    repeat (4) step();
    checkOutput("flush_no_issue", alu_ena, 0);
    checkOutput("flush_queue", expQ.size(), 0);

    // Reset while entries wait and one is about to issue.
    applyStimulus(OP_SUB, 0, 1, 4'd14, 4'd0, 1'b0, 1'b1, 4'd1);
    step();
    applyStimulus(OP_SUB, 0, 2, 4'd14, 4'd0, 1'b0, 1'b1, 4'd2);
    step();
    applyStimulus(OP_ADD, 7, 7, 4'd0, 4'd0, 1'b1, 1'b1, 4'd3);
    step();
    idleInputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("mrst_ena", alu_ena, 0);
    checkOutput("mrst_full", rs_full, 0);
    checkOutput("mrst_b", alu_b, 0);
    checkOutput("mrst_tag", alu_rob_tag, 0);
    driveCdbAlu(4'd14, 5);
    step();
    idleInputs();
    repeat (4) step();
    checkOutput("mrst_no_issue", alu_ena, 0);
    checkOutput("mrst_queue", expQ.size(), 0);

    monOn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
